conv_result_buffer: RTL
=======================

CONV_RESULT_BUFFER -- requirements
Module: conv_result_buffer

Interface
REQ-001 SHALL have parameter MATRIX_DIM, default 16, meaning convolution output grid is MATRIX_DIM x MATRIX_DIM results per frame.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, power of two >= 2, meaning number of buffered results.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  one-cycle result strobe, driven by the convolution engine's done.
REQ-006 SHALL have port in_data  input  DATA_WIDTH (data_t)  accumulated MAC sum, sampled only when in_valid=1.
REQ-007 SHALL have port relu_en  input  1  when 1, a negative result (signed two's complement) is stored as 0.
REQ-008 SHALL have port clear  input  1  synchronous soft clear of FIFO, coordinates and overflow flag.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the head entry.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  head result value.
REQ-012 SHALL have port out_x, out_y  output  $clog2(MATRIX_DIM) each  grid coordinate of head result.
REQ-013 SHALL have port frame_done  output  1  one-cycle pulse when the final result of a frame is pushed.
REQ-014 SHALL have port overflow  output  1  sticky, set when a result is dropped.
REQ-015 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current occupancy.

Function
REQ-016 SHALL push {processed in_data, x, y} on a cycle with in_valid=1 and FIFO not full or popped that same cycle.
REQ-017 SHALL pop when out_valid=1 and out_ready=1; out_data/out_x/out_y hold steady while out_valid=1 and out_ready=0.
REQ-018 SHALL have latency one cycle: push at edge t into an empty FIFO gives out_valid=1 after edge t; no combinational in_valid->out_valid path.
REQ-019 SHALL, when full and in_valid=1 and no pop in the same cycle, drop the result, set overflow, and still advance coordinates (engine cannot be stalled).
REQ-020 SHALL, with simultaneous push and pop when full, accept both and leave level unchanged; when empty, push only (no pop since out_valid=0).
REQ-021 SHALL track write coordinates: x increments per in_valid; at x=MATRIX_DIM-1, x wraps to 0 and y increments; at (MATRIX_DIM-1, MATRIX_DIM-1), both wrap to 0.
REQ-022 SHALL pulse frame_done for exactly one cycle, after the edge on which in_valid occurs at (MATRIX_DIM-1, MATRIX_DIM-1), whether that result was stored or dropped.
REQ-023 SHALL apply ReLU combinationally before storage using relu_en sampled in the push cycle; relu_en=0 stores raw in_data.
REQ-024 SHALL give clear priority over push/pop that cycle: FIFO empty, coordinates (0,0), overflow 0, in_valid in that cycle ignored.
REQ-025 SHALL keep pointers wrapping modulo FIFO_DEPTH, with full/empty derived from level (0 = empty, FIFO_DEPTH = full).

Reset
REQ-026 SHALL, with rst=1 at an edge, set out_valid=0, level=0, frame_done=0, overflow=0, coordinates (0,0), and pointers 0; out_data/out_x/out_y are don't-care while out_valid=0.
REQ-027 SHALL, on rst asserted mid-frame or mid-drain, discard all buffered entries; the first in_valid after reset is coordinate (0,0).
REQ-028 SHALL give rst priority over clear, push and pop.

Structure
REQ-029 SHALL use DATA_WIDTH and data_t from the shared defines header; the FIFO entry struct (data, x, y) SHALL live in a shared package so downstream writeback reuses it.
REQ-030 SHALL implement storage in one sub-module result_fifo (parameterised width/depth, sync reset, clear); coordinate tracking SHALL reuse the existing counter module.
REQ-031 SHALL carry assertions: no push and drop in the same cycle; frame_done never high for 2 consecutive cycles; out_data known when out_valid=1.

Verification
REQ-032 SHALL cover: reset, then in_valid with in_data=5, out_ready=1 -> out_valid=1 next cycle, out_data=5, (x,y)=(0,0), level returns 0.
REQ-033 SHALL cover: relu_en=1, in_data=-3 then 7 -> outputs 0 then 7; relu_en=0, -3 -> -3.
REQ-034 SHALL cover: out_ready=0, 9 strobes, DEPTH=8 -> level=8, overflow=1, 9th dropped; draining yields the first 8 values in order.
REQ-035 SHALL cover: full with push+pop together -> level stays 8, no overflow.
REQ-036 SHALL cover: 256 strobes, MATRIX_DIM=16, out_ready=1 -> frame_done pulses once after the 256th, last (x,y)=(15,15), 257th at (0,0).
REQ-037 SHALL cover: rst after 5 pushes with out_ready=0 -> level=0, out_valid=0, next push at (0,0); clear behaves identically and beats a coincident in_valid.

Source files
------------

// File: rtl/conv_result_buffer_pkg.sv
// Shared result types: the MAC data word and the buffered (data, x, y) entry.
// The writeback stage imports the same package, so the entry layout is defined only here.
package conv_result_buffer_pkg;

  localparam int DATA_WIDTH = 32;
  typedef logic signed [DATA_WIDTH-1:0] data_t;

  // Wide enough for any grid up to 65535 x 65535; each instance uses only the low bits.
  localparam int COORD_W = 16;
  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    data_t  data;
    coord_t x;
    coord_t y;
  } result_entry_t;

  function automatic data_t relu(input data_t d, input logic en);
    return (en && d[DATA_WIDTH-1]) ? '0 : d;
  endfunction

endpackage

// File: rtl/coord_counter.sv
// Modulo-MAX up counter with sync reset/clear; last flags the terminal count.
module coord_counter #(
  parameter int MAX = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   en,
  output logic [$clog2(MAX)-1:0] count,
  output logic                   last
);

  localparam int W = $clog2(MAX);

  assign last = (count == W'(MAX - 1));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (en) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/result_fifo.sv
// Generic synchronous FIFO with registered occupancy; head is read straight from storage.
// Pushes while full are ignored unless a pop happens the same cycle; pops while empty are ignored.
module result_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     not_empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign not_empty = (level != '0);
  assign full      = (level == LW'(DEPTH));
  assign do_pop    = pop && not_empty;
  assign do_push   = push && (!full || do_pop);
  assign rdata     = mem[rd_ptr];

  // Pointers rely on DEPTH being a power of two to wrap for free.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !clear && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/conv_result_buffer.sv
// Buffers convolution results with optional ReLU, tags each with its (x, y) grid position.
// The engine cannot be stalled: results arriving while full are dropped and flagged sticky.
module conv_result_buffer
  import conv_result_buffer_pkg::*;
#(
  parameter int MATRIX_DIM = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  data_t                         in_data,
  input  logic                          relu_en,
  input  logic                          clear,
  input  logic                          out_ready,
  output logic                          out_valid,
  output data_t                         out_data,
  output logic [$clog2(MATRIX_DIM)-1:0] out_x,
  output logic [$clog2(MATRIX_DIM)-1:0] out_y,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int CW = $clog2(MATRIX_DIM);

  logic          accept;
  logic          pop;
  logic          push;
  logic          drop;
  logic          full;
  logic          x_last;
  logic          y_last;
  logic [CW-1:0] cur_x;
  logic [CW-1:0] cur_y;
  result_entry_t wr_entry;
  result_entry_t head;
  logic          unused_coord_hi;

  assign accept = in_valid && !clear;
  assign pop    = out_valid && out_ready;
  assign push   = accept && (!full || pop);
  assign drop   = accept && full && !pop;

  always_comb begin
    wr_entry      = '0;
    wr_entry.data = relu(in_data, relu_en);
    wr_entry.x    = COORD_W'(cur_x);
    wr_entry.y    = COORD_W'(cur_y);
  end

  // Coordinates advance on every accepted strobe, stored or dropped.
  coord_counter #(.MAX(MATRIX_DIM)) u_x_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (accept),
    .count (cur_x),
    .last  (x_last)
  );

  coord_counter #(.MAX(MATRIX_DIM)) u_y_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .en    (accept && x_last),
    .count (cur_y),
    .last  (y_last)
  );

  result_fifo #(
    .WIDTH ($bits(result_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .wdata     (wr_entry),
    .pop       (pop),
    .rdata     (head),
    .not_empty (out_valid),
    .full      (full),
    .level     (level)
  );

  assign out_data        = head.data;
  assign out_x           = head.x[CW-1:0];
  assign out_y           = head.y[CW-1:0];
  assign unused_coord_hi = ^{head.x[COORD_W-1:CW], head.y[COORD_W-1:CW]};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (drop) overflow <= 1'b1;
      frame_done <= accept && x_last && y_last;
    end
  end

  a_no_push_and_drop: assert property (@(posedge clk) disable iff (rst) !(push && drop));
  a_frame_done_single: assert property (@(posedge clk) disable iff (rst) frame_done |=> !frame_done);
  a_out_data_known: assert property (@(posedge clk) disable iff (rst) out_valid |-> !$isunknown(out_data));

endmodule
